// File: rtl/pci_pkg.sv
// Shared definitions for the PCI-style target: bus commands, FSM states,
// bus width and small address-arithmetic helpers used by the decoder.
package pci_pkg;

    localparam int         AD_W          = 32;
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ_TA = 3'd2,
        READ    = 3'd3,
        BUSY    = 3'd4
    } state_e;

    // True when addr falls inside base .. base+depth-1.
    function automatic logic addr_hit(input logic [AD_W-1:0] addr,
                                      input logic [AD_W-1:0] base,
                                      input logic [AD_W-1:0] depth);
        return (addr >= base) && ((addr - base) < depth);
    endfunction

    // Burst address increment that wraps from the last word back to base.
    function automatic logic [AD_W-1:0] addr_next(input logic [AD_W-1:0] addr,
                                                  input logic [AD_W-1:0] base,
                                                  input logic [AD_W-1:0] depth);
        logic [AD_W-1:0] nxt;
        if (addr == (base + depth - 32'd1)) begin
            nxt = base;
        end else begin
            nxt = addr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pci_target_if.sv
// Control/handshake signals of the PCI-style bus. The multiplexed AD bus is a
// true tri-state net and is carried as a separate inout port on the target.
interface pci_target_if;
    logic       Frame;
    logic [3:0] CBE;
    logic       Irdy;
    logic       Devsel;
    logic       Trdy;

    modport master (output Frame, output CBE, output Irdy, input Devsel, input Trdy);
    modport slave  (input Frame, input CBE, input Irdy, output Devsel, output Trdy);
endinterface

// File: rtl/pci_target_mem.sv
// Word memory behind the target: byte-lane synchronous write, combinational
// read. Contents are intentionally not reset.
module pci_target_mem #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem_r [DEPTH];

    // Write only the byte lanes whose enable bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pci_target.sv
// PCI-style 32-bit memory target: Memory Read / Memory Write, single and burst
// transfers, initiator wait states, wrapping address counter.
// Optional macro PCI_TARGET_WAIT_EN inserts one target wait state before the
// first data phase of every transaction.
module pci_target
    import pci_pkg::*;
#(
    parameter logic [AD_W-1:0] BASE_ADDR = 32'd20,
    parameter int              DEPTH     = 16
) (
    input  logic            Clock,
    input  logic            RST,
    pci_target_if.slave     bus,
    inout  wire [AD_W-1:0]  AddressData
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AD_W-1:0] DEPTH_W = AD_W'(DEPTH);

    state_e           state_r, state_s;
    logic [AD_W-1:0]  addr_r, addr_s;
    logic             devsel_r, devsel_s;
    logic             trdy_r, trdy_s;
    logic             oe_r, oe_s;
    logic             wait_r, wait_s;
    logic             we_s, xfer_s, abort_s, hit_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic [AD_W-1:0]  rdata_s;

    assign hit_s     = addr_hit(AddressData, BASE_ADDR, DEPTH_W);
    assign mem_idx_s = IDX_W'(addr_r - BASE_ADDR);

    // Next-state, counter and output-enable decisions for the bus FSM.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        devsel_s = devsel_r;
        trdy_s   = trdy_r;
        oe_s     = oe_r;
        wait_s   = wait_r;
        we_s     = 1'b0;
        xfer_s   = ~bus.Irdy & ~trdy_r;
        abort_s  = bus.Frame & bus.Irdy;
        case (state_r)
            IDLE: begin
                devsel_s = 1'b1;
                trdy_s   = 1'b1;
                oe_s     = 1'b0;
                wait_s   = 1'b0;
                if (!bus.Frame) begin
                    addr_s = AddressData;
                    if (hit_s && (bus.CBE == CMD_MEM_WRITE)) begin
                        state_s  = WRITE;
                        devsel_s = 1'b0;
`ifdef PCI_TARGET_WAIT_EN
                        trdy_s   = 1'b1;
`else
                        trdy_s   = 1'b0;
`endif
                    end else if (hit_s && (bus.CBE == CMD_MEM_READ)) begin
                        state_s  = READ_TA;
                        devsel_s = 1'b0;
`ifdef PCI_TARGET_WAIT_EN
                        wait_s   = 1'b1;
`else
                        wait_s   = 1'b0;
`endif
                    end else begin
                        state_s = BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (abort_s) begin
                    state_s  = IDLE;
                    devsel_s = 1'b1;
                    trdy_s   = 1'b1;
                end else if (trdy_r) begin
                    // Leaving the target wait state: ready from next cycle.
                    trdy_s = 1'b0;
                end else if (xfer_s) begin
                    we_s   = 1'b1;
                    addr_s = addr_next(addr_r, BASE_ADDR, DEPTH_W);
                    if (bus.Frame) begin
                        state_s  = IDLE;
                        devsel_s = 1'b1;
                        trdy_s   = 1'b1;
                    end else begin
                        state_s = WRITE;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            READ_TA: begin
                if (wait_r) begin
                    wait_s = 1'b0;
                end else begin
                    state_s = READ;
                    trdy_s  = 1'b0;
                    oe_s    = 1'b1;
                end
            end
            READ: begin
                if (abort_s) begin
                    state_s  = IDLE;
                    devsel_s = 1'b1;
                    trdy_s   = 1'b1;
                    oe_s     = 1'b0;
                end else if (xfer_s) begin
                    addr_s = addr_next(addr_r, BASE_ADDR, DEPTH_W);
                    if (bus.Frame) begin
                        state_s  = IDLE;
                        devsel_s = 1'b1;
                        trdy_s   = 1'b1;
                        oe_s     = 1'b0;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = READ;
                end
            end
            BUSY: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s  = IDLE;
                devsel_s = 1'b1;
                trdy_s   = 1'b1;
                oe_s     = 1'b0;
                wait_s   = 1'b0;
            end
        endcase
    end

    // FSM state, address counter and registered bus outputs.
    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state_r  <= IDLE;
            addr_r   <= 32'd0;
            devsel_r <= 1'b1;
            trdy_r   <= 1'b1;
            oe_r     <= 1'b0;
            wait_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            devsel_r <= devsel_s;
            trdy_r   <= trdy_s;
            oe_r     <= oe_s;
            wait_r   <= wait_s;
        end
    end

    pci_target_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (Clock),
        .we    (we_s),
        .waddr (mem_idx_s),
        .be    (bus.CBE),
        .wdata (AddressData),
        .raddr (mem_idx_s),
        .rdata (rdata_s)
    );

    assign bus.Devsel  = devsel_r;
    assign bus.Trdy    = trdy_r;
    assign AddressData = oe_r ? rdata_s : {AD_W{1'bz}};

endmodule

// File: tb/tb_pci_target.sv
// Randomized scoreboard bench for pci_target: an initiator model issues
// transactions, a word-array reference model predicts read data, and a
// negedge monitor pops and compares every read data transfer.
module tb_pci_target;

    localparam int BASE  = 20;
    localparam int DEPTH = 16;
`ifdef PCI_TARGET_WAIT_EN
    localparam int WR_LAT = 2;
    localparam int RD_LAT = 3;
`else
    localparam int WR_LAT = 1;
    localparam int RD_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pci_target_if bus();
    wire  [31:0] AddressData;
    logic [31:0] tb_ad;
    logic        tb_ad_en;
    assign AddressData = tb_ad_en ? tb_ad : 32'hzzzzzzzz;
    wire ad_z = (AddressData === 32'hzzzzzzzz);

    pci_target #(.BASE_ADDR(32'd20), .DEPTH(16)) dut (
        .Clock       (clk),
        .RST         (rst_n),
        .bus         (bus),
        .AddressData (AddressData)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [0:35];
    logic [31:0] exp_q [$];
    bit          rd_active = 1'b0;
    logic [31:0] d_a  [8];
    logic [3:0]  be_a [8];
    int          w_a  [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic int nxt(input int a);
        return BASE + ((a - BASE + 1) % DEPTH);
    endfunction

    // Monitor: every read transfer (Irdy=0, Trdy=0) consumes one expected word.
    always @(negedge clk) begin
        if (rd_active && rst_n && !bus.Irdy && !bus.Trdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_extra: got %h required no transfer", AddressData);
            end else begin
                check("read_data", AddressData, exp_q.pop_front());
            end
        end
    end

    // One initiator transaction; data/byte enables/waits come from d_a, be_a, w_a.
    task automatic xact(input int addr, input logic [3:0] cmd, input int n);
        bit wr, rd, hit;
        int lat, a, exp_lat;
        wr  = (cmd == 4'b0111);
        rd  = (cmd == 4'b0110);
        hit = (addr >= BASE) && (addr < BASE + DEPTH);
        bus.Frame = 1'b0; bus.Irdy = 1'b1; bus.CBE = cmd;
        tb_ad_en = 1'b1; tb_ad = 32'(addr);
        cyc();
        if (!(hit && (wr || rd))) begin
            for (int k = 0; k < 3; k++) begin
                check("ignore_devsel", {31'd0, bus.Devsel}, 32'd1);
                check("ignore_trdy", {31'd0, bus.Trdy}, 32'd1);
                bus.Irdy = 1'b0; bus.CBE = 4'hF; tb_ad = $urandom;
                cyc();
            end
            check("ignore_devsel_end", {31'd0, bus.Devsel}, 32'd1);
            bus.Frame = 1'b1; bus.Irdy = 1'b1; tb_ad_en = 1'b0;
            cyc(); cyc();
            return;
        end
        check("devsel_assert", {31'd0, bus.Devsel}, 32'd0);
        if (rd) begin
            tb_ad_en = 1'b0;
            a = addr;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(ref_mem[a]);
                a = nxt(a);
            end
            rd_active = 1'b1;
            exp_lat = RD_LAT;
            #1;
        end else begin
            exp_lat = WR_LAT;
        end
        lat = 1;
        while (bus.Trdy !== 1'b0 && lat < 8) begin
            if (rd) check("turnaround_z", {31'd0, ad_z}, 32'd1);
            bus.CBE = rd ? 4'hF : be_a[0];
            if (wr) tb_ad = d_a[0];
            cyc();
            lat++;
        end
        check("trdy_latency", 32'(lat), 32'(exp_lat));
        a = addr;
        for (int i = 0; i < n; i++) begin
            bus.CBE = rd ? 4'hF : be_a[i];
            if (wr) tb_ad = d_a[i];
            for (int w = 0; w < w_a[i]; w++) begin
                bus.Frame = 1'b0; bus.Irdy = 1'b1;
                cyc();
                check("wait_hold_trdy", {31'd0, bus.Trdy}, 32'd0);
                if (rd && exp_q.size() > 0) check("wait_hold_ad", AddressData, exp_q[0]);
            end
            bus.Irdy = 1'b0; bus.Frame = (i == n - 1);
            cyc();
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_a[i][b]) ref_mem[a][8*b +: 8] = d_a[i][8*b +: 8];
                end
            end
            a = nxt(a);
        end
        bus.Irdy = 1'b1; bus.Frame = 1'b1; tb_ad_en = 1'b0; rd_active = 1'b0;
        #1;
        check("release_devsel", {31'd0, bus.Devsel}, 32'd1);
        check("release_trdy", {31'd0, bus.Trdy}, 32'd1);
        check("release_ad_z", {31'd0, ad_z}, 32'd1);
        check("read_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, sel, a, n;
        rst_n = 1'b0; bus.Frame = 1'b1; bus.Irdy = 1'b1; bus.CBE = 4'h7;
        tb_ad_en = 1'b0; tb_ad = 32'd0;
        for (int i = 0; i < 8; i++) begin
            d_a[i] = 32'd0; be_a[i] = 4'hF; w_a[i] = 0;
        end
        // Reset held with Frame toggling.
        for (int k = 0; k < 4; k++) begin
            bus.Frame = k[0];
            cyc();
            check("reset_devsel", {31'd0, bus.Devsel}, 32'd1);
            check("reset_trdy", {31'd0, bus.Trdy}, 32'd1);
            check("reset_ad_z", {31'd0, ad_z}, 32'd1);
        end
        bus.Frame = 1'b1;
        rst_n = 1'b1;
        cyc();

        // Write burst with one initiator wait.
        d_a[0] = 32'h11111111; d_a[1] = 32'h22222222; d_a[2] = 32'h33333333;
        be_a[0] = 4'hF; be_a[1] = 4'hF; be_a[2] = 4'hF;
        w_a[0] = 0; w_a[1] = 1; w_a[2] = 0;
        xact(23, 4'b0111, 3);
        // Preload 21, 22.
        d_a[0] = 32'hAAAA0001; d_a[1] = 32'hAAAA0002; w_a[1] = 0;
        xact(21, 4'b0111, 2);
        // Read burst on consecutive edges.
        xact(21, 4'b0110, 3);
        // Address miss, unsupported command, then a normal read.
        xact(5, 4'b0111, 1);
        xact(22, 4'b0011, 1);
        xact(23, 4'b0110, 1);
        // Byte enables over 0x22222222.
        d_a[0] = 32'hDEADBEEF; be_a[0] = 4'b0011;
        xact(24, 4'b0111, 1);
        xact(24, 4'b0110, 1);
        // All byte enables off: memory unchanged.
        d_a[0] = 32'hFFFFFFFF; be_a[0] = 4'b0000;
        xact(25, 4'b0111, 1);
        xact(25, 4'b0110, 1);
        // Wrap-around write and read-back.
        d_a[0] = 32'h35353535; d_a[1] = 32'h20202020; be_a[0] = 4'hF; be_a[1] = 4'hF;
        xact(35, 4'b0111, 2);
        w_a[0] = 1;
        xact(35, 4'b0110, 2);
        w_a[0] = 0;

        // Reset asserted in the middle of a read data phase.
        bus.Frame = 1'b0; bus.Irdy = 1'b1; bus.CBE = 4'b0110; tb_ad_en = 1'b1; tb_ad = 32'd30;
        cyc();
        tb_ad_en = 1'b0;
        lat = 0;
        while (bus.Trdy !== 1'b0 && lat < 8) begin
            cyc();
            lat++;
        end
        #1;
        check("midrst_ad_driven", {31'd0, ad_z}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_devsel", {31'd0, bus.Devsel}, 32'd1);
        check("midrst_trdy", {31'd0, bus.Trdy}, 32'd1);
        check("midrst_ad_z", {31'd0, ad_z}, 32'd1);
        bus.Frame = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Random phase: initialise every word, then mixed traffic.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                d_a[i] = $urandom; be_a[i] = 4'hF; w_a[i] = $urandom_range(0, 1);
            end
            xact(BASE + 8 * s, 4'b0111, 8);
        end
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(20, 35);
            n   = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) begin
                d_a[i] = $urandom; be_a[i] = 4'($urandom_range(0, 15)); w_a[i] = $urandom_range(0, 2);
            end
            if (sel < 4) begin
                xact(a, 4'b0111, n);
            end else if (sel < 9) begin
                xact(a, 4'b0110, n);
            end else begin
                xact($urandom_range(0, 19), 4'b0111, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
